c_rr_mux_n: RTL and testbench

C_RR_MUX_N -- requirements
Module: c_rr_mux_n

---
 rtl/c_rr_mux_n.sv | 146 ++++++++++++++
 tb/tb_c_rr_mux_n.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_rr_mux_n.sv
// c_rr_mux_n: N-way registered multiplexer with a fixed-select mode and a
// round-robin arbitration mode. One output register holds the selected word.
// The register is refilled whenever it is empty or being drained, so the
// block sustains one word per cycle.
module c_rr_mux_n #(
  parameter  int WIDTH = 16,
  parameter  int WAYS  = 8,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Round-robin pointer: the last granted channel. The search starts just after it.
  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Output holding register
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;

  // Arbitration signals
  logic             load_en;
  logic [SEL_W-1:0] fixed_idx;
  logic             fixed_ok;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_ok;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_ok;
  logic             xfer;
  logic [WIDTH-1:0] grant_word;
  logic [15:0]      valid_ext;

  // The register may take a new word when it is empty or its word leaves this cycle.
  // Reset blocks every load so that nothing is accepted during a reset cycle.
  assign load_en = !reset && (!out_valid_q || out_ready);

  // Widen the valid vector to 16 bits so the search can index it with a 4-bit channel number.
  assign valid_ext = 16'(in_valid);

  // Fixed-select candidate: an out-of-range sel (possible when WAYS is not a power of two) grants nothing.
  always_comb begin
    fixed_idx = sel;
    fixed_ok  = (int'(sel) < WAYS);
  end

  // Round-robin candidate: the first valid channel at ptr+1, ptr+2, ... modulo WAYS.
  // The loop scans from the farthest offset to the nearest, so the closest valid channel is assigned last and wins.
  always_comb begin
    int cand;
    cand   = 0;
    rr_idx = '0;
    rr_ok  = 1'b0;
    for (int off = WAYS; off >= 1; off--) begin
      cand = (int'(ptr_q) + off) % WAYS;
      if (valid_ext[cand[3:0]]) begin
        rr_idx = SEL_W'(cand);
        rr_ok  = 1'b1;
      end
    end
  end

  // Choose between the fixed and the round-robin candidate for the current mode.
  always_comb begin
    grant_idx = fixed_idx;
    grant_ok  = fixed_ok;
    if (mode) begin
      grant_idx = rr_idx;
      grant_ok  = rr_ok;
    end
  end

  // Assert at most one ready bit, for the granted channel, and only when the register can load.
  always_comb begin
    in_ready = '0;
    if (load_en && grant_ok) begin
      for (int i = 0; i < WAYS; i++) begin
        if (grant_idx == SEL_W'(i)) begin
          in_ready[i] = 1'b1;
        end
      end
    end
  end

  // An input transfer happens when the single ready channel also presents valid data.
  assign xfer = |(in_ready & in_valid);

  // Data multiplexer that picks the granted channel's word.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic: load on an input transfer, otherwise drain on an output transfer.
  // The pointer moves only on a round-robin transfer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = grant_word;
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers. Reset discards any held word and points the arbiter at WAYS-1,
  // so channel 0 has the highest priority first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(WAYS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_c_rr_mux_n.sv
// Testbench for c_rr_mux_n: an 8-way and a 5-way instance share the same stimulus.
// Both are checked every cycle against a behavioural model, and directed
// scenarios pin the model with hand-computed literals.
module tb_c_rr_mux_n;
   localparam int W      = 16;
   localparam int WAYS_A = 8;
   localparam int WAYS_B = 5;
   localparam int SW     = 3;

   logic                clk      = 1'b0;
   logic                reset    = 1'b1;
   logic                mode     = 1'b0;
   logic [SW-1:0]       sel      = '0;
   logic [WAYS_A*W-1:0] inData   = '0;
   logic [WAYS_A-1:0]   inValid  = '0;
   logic                outReady = 1'b0;

   logic [WAYS_A-1:0] readyA;
   logic [W-1:0]      dataA;
   logic [SW-1:0]     chanA;
   logic              validA;
   logic [WAYS_B-1:0] readyB;
   logic [W-1:0]      dataB;
   logic [SW-1:0]     chanB;
   logic              validB;

   int checks = 0;
   int errors = 0;

   // Abstract state: the held word, its channel, and the last granted channel
   typedef struct packed {
      logic        v;
      logic [15:0] d;
      logic [3:0]  chan;
      logic [3:0]  ptr;
   } modelState;

   modelState mA;
   modelState mB;

   c_rr_mux_n #(.WIDTH(W), .WAYS(WAYS_A)) dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(inData), .in_valid(inValid), .in_ready(readyA),
      .out_data(dataA), .out_chan(chanA), .out_valid(validA), .out_ready(outReady)
   );

   c_rr_mux_n #(.WIDTH(W), .WAYS(WAYS_B)) dut5 (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(inData[WAYS_B*W-1:0]), .in_valid(inValid[WAYS_B-1:0]), .in_ready(readyB),
      .out_data(dataB), .out_chan(chanB), .out_valid(validB), .out_ready(outReady)
   );

   // Free-running clock with a 10-unit period
   always #5 clk = ~clk;

   function automatic modelState resetState(int ways);
      modelState s;
      s.v    = 1'b0;
      s.d    = '0;
      s.chan = '0;
      s.ptr  = 4'(ways - 1);
      return s;
   endfunction

   // Which channel may transfer this cycle: nothing if reset or the word is stuck,
   // otherwise sel in fixed mode, or the first valid channel after ptr in round-robin mode
   function automatic logic [15:0] expReady(modelState st, int ways, logic rst, logic m,
                                            logic [2:0] s, logic [15:0] v, logic ordy);
      logic [15:0] r;
      r = '0;
      if (rst || (st.v && !ordy)) return r;
      if (!m) begin
         if (int'(s) < ways) r[s] = 1'b1;
         return r;
      end
      for (int k = 1; k <= ways; k++) begin
         int c;
         c = (int'(st.ptr) + k) % ways;
         if (v[c[3:0]]) begin
            r[c[3:0]] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   function automatic modelState nextState(modelState st, int ways, logic rst, logic m,
                                           logic [2:0] s, logic [15:0] v,
                                           logic [WAYS_A*W-1:0] data, logic ordy);
      modelState n;
      logic [15:0] hit;
      if (rst) return resetState(ways);
      n   = st;
      hit = expReady(st, ways, rst, m, s, v, ordy) & v;
      for (int i = 0; i < ways; i++) begin
         if (hit[i]) begin
            n.v    = 1'b1;
            n.d    = data[i*W +: W];
            n.chan = 4'(i);
            if (m) n.ptr = 4'(i);
            return n;
         end
      end
      if (ordy) n.v = 1'b0;
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic m, input logic [2:0] s, input logic [7:0] v, input logic r);
      mode     = m;
      sel      = s;
      inValid  = v;
      outReady = r;
   endtask

   task automatic setWord(input int ch, input logic [15:0] w);
      inData[ch*W +: W] = w;
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Compare process: at every falling edge, check both DUTs against the model, then advance the model
   initial begin
      mA = resetState(WAYS_A);
      mB = resetState(WAYS_B);
      forever begin
         @(negedge clk);
         checkOutput("ready_a", 32'(readyA),
                     32'(expReady(mA, WAYS_A, reset, mode, sel, 16'(inValid), outReady)));
         checkOutput("valid_a", 32'(validA), 32'(mA.v));
         checkOutput("data_a",  32'(dataA),  32'(mA.d));
         checkOutput("chan_a",  32'(chanA),  32'(mA.chan));
         checkOutput("ready_b", 32'(readyB),
                     32'(expReady(mB, WAYS_B, reset, mode, sel, 16'(inValid[WAYS_B-1:0]), outReady)));
         checkOutput("valid_b", 32'(validB), 32'(mB.v));
         checkOutput("data_b",  32'(dataB),  32'(mB.d));
         checkOutput("chan_b",  32'(chanB),  32'(mB.chan));
         mA = nextState(mA, WAYS_A, reset, mode, sel, 16'(inValid), inData, outReady);
         mB = nextState(mB, WAYS_B, reset, mode, sel, 16'(inValid[WAYS_B-1:0]), inData, outReady);
      end
   end

   // Directed scenarios, then randomized traffic
   initial begin
      int expSeq[3];
      expSeq = '{6, 2, 6};
      for (int ch = 0; ch < WAYS_A; ch++) setWord(ch, 16'(16'hC000 + ch));
      applyStimulus(1'b0, 3'd1, 8'h00, 1'b0);

      // Reset state
      repeat (2) stepEdge();
      checkOutput("rst_valid", 32'(validA), 32'd0);
      checkOutput("rst_data",  32'(dataA),  32'd0);
      checkOutput("rst_chan",  32'(chanA),  32'd0);
      checkOutput("rst_ready", 32'(readyA), 32'd0);
      reset = 1'b0;

      // Out-of-range sel on the 5-way instance grants nothing
      applyStimulus(1'b0, 3'd6, 8'hFF, 1'b1);
      #1;
      checkOutput("sel6_ready_b", 32'(readyB), 32'd0);
      checkOutput("sel6_ready_a", 32'(readyA), 32'h40);
      stepEdge();
      checkOutput("sel6_valid_b", 32'(validB), 32'd0);
      checkOutput("sel6_valid_a", 32'(validA), 32'd1);
      checkOutput("sel6_chan_a",  32'(chanA),  32'd6);

      // Fixed select of channel 3
      setWord(3, 16'hBEEF);
      applyStimulus(1'b0, 3'd3, 8'hFF, 1'b1);
      #1;
      checkOutput("fix_ready", 32'(readyA), 32'h08);
      stepEdge();
      checkOutput("fix_data",  32'(dataA),  32'hBEEF);
      checkOutput("fix_chan",  32'(chanA),  32'd3);
      checkOutput("fix_valid", 32'(validA), 32'd1);
      checkOutput("fix_ready2", 32'(readyA), 32'h08);
      setWord(3, 16'h1234);
      stepEdge();
      checkOutput("bp_load", 32'(dataA), 32'h1234);

      // Backpressure: the word holds while sel and data toggle
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 3'(i), 8'hFF, 1'b0);
         setWord(i, 16'($urandom));
         #1;
         checkOutput("bp_ready", 32'(readyA), 32'd0);
         stepEdge();
         checkOutput("bp_data",  32'(dataA),  32'h1234);
         checkOutput("bp_chan",  32'(chanA),  32'd3);
         checkOutput("bp_valid", 32'(validA), 32'd1);
      end
      setWord(5, 16'h5555);
      applyStimulus(1'b0, 3'd5, 8'hFF, 1'b1);
      #1;
      checkOutput("bp_release_ready", 32'(readyA), 32'h20);
      stepEdge();
      checkOutput("bp_next_data", 32'(dataA), 32'h5555);
      checkOutput("bp_next_chan", 32'(chanA), 32'd5);

      // Reset while a word is held
      setWord(1, 16'hAAAA);
      applyStimulus(1'b0, 3'd1, 8'hFF, 1'b1);
      stepEdge();
      checkOutput("mid_load", 32'(dataA), 32'hAAAA);
      outReady = 1'b0;
      reset    = 1'b1;
      #1;
      checkOutput("mid_rst_ready", 32'(readyA), 32'd0);
      stepEdge();
      checkOutput("mid_rst_valid", 32'(validA), 32'd0);
      checkOutput("mid_rst_data",  32'(dataA),  32'd0);
      checkOutput("mid_rst_chan",  32'(chanA),  32'd0);
      reset = 1'b0;

      // Round-robin with all channels valid, starting from channel 0
      for (int ch = 0; ch < WAYS_A; ch++) setWord(ch, 16'(16'h1000 + ch));
      applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
      #1;
      checkOutput("rr_first_ready", 32'(readyA), 32'h01);
      for (int k = 0; k < 9; k++) begin
         stepEdge();
         checkOutput("rr_chan",  32'(chanA),  32'(k % 8));
         checkOutput("rr_data",  32'(dataA),  32'(16'h1000 + (k % 8)));
         checkOutput("rr_valid", 32'(validA), 32'd1);
      end

      // Sparse arbitration: move ptr to 5, then alternate between channels 6 and 2
      applyStimulus(1'b1, 3'd0, 8'h20, 1'b1);
      stepEdge();
      checkOutput("sparse_ptr5", 32'(chanA), 32'd5);
      applyStimulus(1'b1, 3'd0, 8'h44, 1'b1);
      #1;
      checkOutput("sparse_ready", 32'(readyA), 32'h40);
      for (int j = 0; j < 3; j++) begin
         stepEdge();
         checkOutput("sparse_chan", 32'(chanA), 32'(expSeq[j]));
      end

      // Randomized traffic, checked by the compare process
      repeat (3000) begin
         stepEdge();
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
         inValid = 8'($urandom);
         for (int ch = 0; ch < WAYS_A; ch++) setWord(ch, 16'($urandom));
         outReady = ($urandom_range(0, 9) < 7);
      end
      stepEdge();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
